// File: rtl/tcp_option_encoder.sv
// tcp_option_encoder: latches requested TCP options and streams them as padded 32-bit big-endian words
module tcp_option_encoder #(
   parameter int MAX_OPT_WORDS = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [8:0]  option_en,
   input  logic [15:0] mss,
   input  logic [7:0]  scale_wnd,
   input  logic [2:0]  sack_nbr,
   input  logic [63:0] sack_n0,
   input  logic [63:0] sack_n1,
   input  logic [63:0] sack_n2,
   input  logic [63:0] sack_n3,
   input  logic [63:0] time_stp,
   output logic [31:0] data,
   output logic        data_valid,
   input  logic        data_ready,
   output logic        data_last,
   output logic        busy,
   output logic        done,
   output logic [3:0]  opt_len_words,
   output logic [3:0]  hdr_len,
   output logic        sack_trunc,
   output logic        option_err
);
   typedef enum logic [3:0] {IDLE, MSS, TSH, TSV, TSE, SP, WS, SKH, SKB} state_t;

   // segment flags: {sack, ws, sperm_only, ts, mss}; returns the first enabled segment
   function automatic state_t pick(input logic [4:0] f);
      return f[0] ? MSS : f[1] ? TSH : f[2] ? SP : f[3] ? WS : f[4] ? SKH : IDLE;
   endfunction

   state_t          state, state_nx, adv;
   logic [4:0]      flags, f_in;
   logic            sp_r, done_nx, hs, accept;
   logic [15:0]     mss_r;
   logic [7:0]      scale_r;
   logic [63:0]     ts_r;
   logic [3:0][63:0] blk_r;
   logic [2:0]      n_r, cnt, n_in;
   logic [3:0]      w_in, len_in;
   logic            err_in, fits_in, sk_in, trunc_in;
   int              avail;
   logic            unused;

   assign unused     = ^{option_en[7:6], option_en[1:0]};
   assign data_valid = state != IDLE;
   assign busy       = data_valid | done;
   assign accept     = start & ~busy;
   assign hs         = data_valid & data_ready;
   assign data_last  = data_valid && adv == IDLE;
   assign hdr_len    = 4'd5 + opt_len_words;

   // size the request from the raw inputs: non-SACK words, then how many SACK blocks still fit
   always_comb begin
      w_in     = {3'b0, option_en[2]} + (option_en[8] ? 4'd3 : {3'b0, option_en[4]}) + {3'b0, option_en[3]};
      err_in   = option_en[5] && (sack_nbr == 3'd0 || sack_nbr > 3'd4);
      avail    = MAX_OPT_WORDS - int'(w_in) - 1;
      fits_in  = 2 * int'(sack_nbr) <= avail;
      n_in     = fits_in ? sack_nbr : (avail > 1 ? 3'(avail / 2) : 3'd0);
      sk_in    = option_en[5] && !err_in && n_in != 3'd0;
      trunc_in = option_en[5] && !err_in && !fits_in;
      len_in   = w_in + (sk_in ? 4'(2 * n_in + 1) : 4'd0);
      f_in     = {sk_in, option_en[3], option_en[4] && !option_en[8], option_en[8], option_en[2]};
   end

   // segment sequencing: disabled segments are skipped in the same cycle
   always_comb begin
      adv = IDLE;
      case (state)
         MSS:     adv = pick(flags & 5'b11110);
         TSH:     adv = TSV;
         TSV:     adv = TSE;
         TSE:     adv = pick(flags & 5'b11100);
         SP:      adv = pick(flags & 5'b11000);
         WS:      adv = pick(flags & 5'b10000);
         SKH:     adv = SKB;
         SKB:     adv = cnt == 3'(2 * n_r - 1) ? IDLE : SKB;
         default: adv = IDLE;
      endcase
      state_nx = data_valid ? (hs ? adv : state) : (accept ? pick(f_in) : IDLE);
      done_nx  = data_valid ? (hs && adv == IDLE) : (accept && f_in == 5'd0);
   end

   // word formatting from the latched request; holds while the sink stalls
   always_comb begin
      data = '0;
      case (state)
         MSS:     data = {16'h0204, mss_r};
         TSH:     data = sp_r ? 32'h0402080A : 32'h0101080A;
         TSV:     data = ts_r[63:32];
         TSE:     data = ts_r[31:0];
         SP:      data = 32'h01010402;
         WS:      data = {24'h010303, scale_r};
         SKH:     data = {24'h010105, 8'(2 + 8 * n_r)};
         SKB:     data = cnt[0] ? blk_r[cnt[2:1]][31:0] : blk_r[cnt[2:1]][63:32];
         default: data = '0;
      endcase
   end

   // state register and request latch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         done          <= 1'b0;
         flags         <= '0;
         sp_r          <= 1'b0;
         mss_r         <= '0;
         scale_r       <= '0;
         ts_r          <= '0;
         blk_r         <= '0;
         n_r           <= '0;
         cnt           <= '0;
         opt_len_words <= '0;
         sack_trunc    <= 1'b0;
         option_err    <= 1'b0;
      end else begin
         state <= state_nx;
         done  <= done_nx;
         if (accept) begin
            flags         <= f_in;
            sp_r          <= option_en[4];
            mss_r         <= mss;
            scale_r       <= scale_wnd;
            ts_r          <= time_stp;
            blk_r         <= {sack_n3, sack_n2, sack_n1, sack_n0};
            n_r           <= sk_in ? n_in : 3'd0;
            cnt           <= '0;
            opt_len_words <= len_in;
            sack_trunc    <= trunc_in;
            option_err    <= err_in;
         end else if (state == SKB && hs) begin
            cnt <= cnt + 3'd1;
         end
      end
   end
endmodule

// File: tb/tb_tcp_option_encoder.sv
// tb_tcp_option_encoder: randomized scoreboard bench against a byte-list model of the option layout
module tb_tcp_option_encoder;
   localparam int MAXW = 10;

   typedef struct {
      int   len;
      logic trunc;
      logic err;
   } meta_t;

   logic        clk = 0, reset = 0, start = 0, data_ready = 1;
   logic [8:0]  option_en = '0;
   logic [15:0] mss = '0;
   logic [7:0]  scale_wnd = '0;
   logic [2:0]  sack_nbr = '0;
   logic [63:0] sack_n0 = '0, sack_n1 = '0, sack_n2 = '0, sack_n3 = '0, time_stp = '0;
   logic [31:0] data;
   logic        data_valid, data_last, busy, done, sack_trunc, option_err;
   logic [3:0]  opt_len_words, hdr_len;

   int          vectors = 0, miscompares = 0;
   int          mode = 0;
   int          mon_n = 0;
   logic        prev_stall = 0, prev_go = 0, prev_last = 0;
   logic [31:0] prev_data = '0;
   logic [32:0] word_q[$];
   meta_t       meta_q[$];
   logic [7:0]  mb[$];

   tcp_option_encoder #(.MAX_OPT_WORDS(MAXW)) dut (
      .clk(clk), .reset(reset), .start(start), .option_en(option_en), .mss(mss),
      .scale_wnd(scale_wnd), .sack_nbr(sack_nbr), .sack_n0(sack_n0), .sack_n1(sack_n1),
      .sack_n2(sack_n2), .sack_n3(sack_n3), .time_stp(time_stp), .data(data),
      .data_valid(data_valid), .data_ready(data_ready), .data_last(data_last), .busy(busy),
      .done(done), .opt_len_words(opt_len_words), .hdr_len(hdr_len), .sack_trunc(sack_trunc),
      .option_err(option_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [32:0] got, input logic [32:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic put32(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) mb.push_back(w[k*8 +: 8]);
   endtask

   // reference: build the byte list option by option, then cut it into words
   task automatic model(input logic [8:0] en, input logic [15:0] m, input logic [7:0] s,
                        input logic [2:0] nb, input logic [3:0][63:0] bl, input logic [63:0] t,
                        output int nw);
      int    wo, n;
      logic  err, trunc;
      meta_t e;
      mb.delete();
      if (en[2]) put32({16'h0204, m});
      if (en[8]) begin
         put32(en[4] ? 32'h0402080A : 32'h0101080A);
         put32(t[63:32]);
         put32(t[31:0]);
      end else if (en[4]) put32(32'h01010402);
      if (en[3]) put32({24'h010303, s});
      wo = mb.size() / 4;
      err = en[5] && (nb == 0 || nb > 4);
      n = 0;
      trunc = 0;
      if (en[5] && !err) begin
         n = int'(nb);
         while (n > 0 && wo + 1 + 2 * n > MAXW) begin
            n--;
            trunc = 1;
         end
      end
      if (n > 0) begin
         put32({24'h010105, 8'(2 + 8 * n)});
         for (int i = 0; i < n; i++) begin
            put32(bl[i][63:32]);
            put32(bl[i][31:0]);
         end
      end
      nw = mb.size() / 4;
      for (int i = 0; i < nw; i++)
         word_q.push_back({i == nw - 1, mb[4*i], mb[4*i+1], mb[4*i+2], mb[4*i+3]});
      e.len = nw;
      e.trunc = trunc;
      e.err = err;
      meta_q.push_back(e);
   endtask

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (busy) begin
         miscompares++;
         $display("FAIL idle_timeout: busy still 1 after %0d cycles", k);
      end
   endtask

   task automatic send(input logic [8:0] en, input logic [15:0] m, input logic [7:0] s,
                       input logic [2:0] nb, input logic [3:0][63:0] bl, input logic [63:0] t);
      int nw;
      wait_idle();
      option_en = en; mss = m; scale_wnd = s; sack_nbr = nb; time_stp = t;
      sack_n0 = bl[0]; sack_n1 = bl[1]; sack_n2 = bl[2]; sack_n3 = bl[3];
      model(en, m, s, nb, bl, t, nw);
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
      option_en = 9'($urandom); mss = 16'($urandom); scale_wnd = 8'($urandom);
      sack_nbr = 3'($urandom); time_stp = {$urandom, $urandom};
      sack_n0 = {$urandom, $urandom}; sack_n3 = {$urandom, $urandom};
      @(negedge clk);
      chk("accept_busy", 33'(busy), 33'd1);
      chk("accept_valid", 33'(data_valid), 33'(nw > 0));
      chk("accept_done", 33'(done), 33'(nw == 0));
   endtask

   task automatic chk_reset();
      chk("rst_valid", 33'(data_valid), 33'd0);
      chk("rst_busy", 33'(busy), 33'd0);
      chk("rst_done", 33'(done), 33'd0);
      chk("rst_last", 33'(data_last), 33'd0);
      chk("rst_data", 33'(data), 33'd0);
      chk("rst_hdr_len", 33'(hdr_len), 33'd5);
      chk("rst_opt_len", 33'(opt_len_words), 33'd0);
      chk("rst_flags", 33'({sack_trunc, option_err}), 33'd0);
   endtask

   // ready generator: 0 = always ready, 1 = random stalls, 2 = driven by the stimulus process
   always @(posedge clk) begin
      #1;
      if (mode == 0) data_ready = 1;
      else if (mode == 1) data_ready = ($urandom_range(0, 3) != 0);
   end

   // monitor: pops expected words on each handshake and request results on each done
   always @(negedge clk) begin
      logic [32:0] e;
      meta_t       m;
      if (!reset) begin
         mon_n = 0;
         prev_stall = 0;
         prev_go = 0;
      end else begin
         if (prev_stall) chk("stall_hold", {data_valid, data}, {1'b1, prev_data});
         if (prev_stall) chk("stall_last", 33'(data_last), 33'(prev_last));
         if (prev_go) chk("no_bubble", 33'(data_valid), 33'd1);
         if (data_valid && data_ready) begin
            if (word_q.size() == 0) chk("unexpected_word", {data_last, data}, 33'h0);
            else begin
               e = word_q.pop_front();
               chk("word", {data_last, data}, e);
            end
            mon_n++;
         end
         if (done) begin
            if (meta_q.size() == 0) chk("unexpected_done", 33'(done), 33'd0);
            else begin
               m = meta_q.pop_front();
               chk("opt_len_words", 33'(opt_len_words), 33'(m.len));
               chk("hdr_len", 33'(hdr_len), 33'(5 + m.len));
               chk("sack_trunc", 33'(sack_trunc), 33'(m.trunc));
               chk("option_err", 33'(option_err), 33'(m.err));
               chk("word_count", 33'(mon_n), 33'(m.len));
            end
            mon_n = 0;
         end
         prev_stall = data_valid && !data_ready;
         prev_go = data_valid && data_ready && !data_last;
         prev_data = data;
         prev_last = data_last;
      end
   end

   initial begin
      #1_000_000;
      miscompares++;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      logic [3:0][63:0] bl;
      logic [63:0]      t;
      bl = {64'h44444444_55555555, 64'h33333333_cccccccc, 64'h22222222_bbbbbbbb, 64'h11111111_aaaaaaaa};
      #2;
      chk_reset();
      repeat (2) @(negedge clk);
      reset = 1;
      // MSS only
      send(9'h004, 16'h05B4, 8'd0, 3'd0, bl, 64'd0);
      // SYN set, sink always ready
      send(9'h11C, 16'h0578, 8'd7, 3'd0, bl, 64'h00000001_00000000);
      // SACK truncation
      send(9'h124, 16'h1234, 8'd0, 3'd4, bl, 64'hdeadbeef_cafef00d);
      // SYN set with three stall cycles on the second word
      mode = 2;
      data_ready = 1;
      send(9'h11C, 16'h0578, 8'd7, 3'd0, bl, 64'h00000001_00000000);
      @(posedge clk);
      #1;
      data_ready = 0;
      chk("bp_word2", {data_valid, data}, {1'b1, 32'h0402080A});
      repeat (3) @(posedge clk);
      #1;
      data_ready = 1;
      mode = 0;
      // erroneous SACK alone is an empty request
      send(9'h020, 16'h0, 8'd0, 3'd0, bl, 64'd0);
      send(9'h02C, 16'h0abc, 8'd3, 3'd5, bl, 64'd0);
      // all SACK block counts with WS only
      for (int i = 1; i <= 4; i++) send(9'h028, 16'h0, 8'd14, 3'(i), bl, 64'd0);
      // start while busy is ignored
      send(9'h13C, 16'h0218, 8'd2, 3'd2, bl, 64'h01020304_05060708);
      option_en = 9'h004;
      mss = 16'hffff;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
      // async reset in the middle of a frame
      send(9'h13C, 16'h0218, 8'd2, 3'd2, bl, 64'h01020304_05060708);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 0;
      #1;
      chk_reset();
      word_q.delete();
      meta_q.delete();
      @(negedge clk);
      @(posedge clk);
      #2;
      reset = 1;
      send(9'h004, 16'h05B4, 8'd0, 3'd0, bl, 64'd0);
      // randomized requests with random backpressure
      mode = 1;
      repeat (300) begin
         for (int i = 0; i < 4; i++) bl[i] = {$urandom, $urandom};
         t = {$urandom, $urandom};
         send(9'($urandom), 16'($urandom), 8'($urandom), 3'($urandom), bl, t);
      end
      wait_idle();
      repeat (3) @(negedge clk);
      chk("queues_drained", 33'(word_q.size() + meta_q.size()), 33'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
